// File: rtl/ex_pkg.sv
// Shared opcodes, state encoding and control-bundle type for the execute stage.
package ex_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam int MUL_CYCLES = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    // Control bits forwarded to the RAM stage, packed in port order.
    typedef struct packed {
        logic e_read_ram;
        logic e_write_ram;
        logic demux;
        logic e_write_br;
    } uc_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock, MUL_CYCLES steps.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] acc_step;

    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done     = run_q && (cnt_q == CNT_W'(MUL_CYCLES - 1));
        // The final step's sum is the product; the caller samples it while done is high.
        result   = acc_step;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU decode and execute/memory boundary registers.
// Define EX_MUL_EN to add the iterative multiplier and the upstream stall.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_uc_e_read_ram,
    input  logic              i_uc_e_write_ram,
    input  logic              i_uc_demux,
    input  logic [3:0]        i_uc_alu_opcode,
    input  logic              i_uc_e_write_br,
    input  logic [ADDR_W-1:0] i_wA,
    input  logic [DATA_W-1:0] i_DR1,
    input  logic [DATA_W-1:0] i_DR2,
    output logic              o_stall,
    output logic              o_valid,
    output logic              o_uc_e_read_ram,
    output logic              o_uc_e_write_ram,
    output logic              o_uc_demux,
    output logic              o_uc_e_write_br,
    output logic [ADDR_W-1:0] o_wA,
    output logic [DATA_W-1:0] o_alu_result,
    output logic              o_zero,
    output logic [DATA_W-1:0] o_DR2
);
    // state   | meaning
    // ST_IDLE | accepting; single-cycle ops retire on the accepting edge
    // ST_BUSY | multiplier iterating; inputs ignored, upstream held by o_stall

    uc_t               uc_in, uc_q, uc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] dr2_q, dr2_d;
    logic [DATA_W-1:0] alu_res;
    logic              take_single;

    assign uc_in = {i_uc_e_read_ram, i_uc_e_write_ram, i_uc_demux, i_uc_e_write_br};

    always_comb begin
        alu_res = '0;
        case (i_uc_alu_opcode)
            OP_AND:  alu_res = i_DR1 & i_DR2;
            OP_OR:   alu_res = i_DR1 | i_DR2;
            OP_ADD:  alu_res = i_DR1 + i_DR2;
            OP_SUB:  alu_res = i_DR1 - i_DR2;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_DR1) < $signed(i_DR2))};
            OP_NOR:  alu_res = ~(i_DR1 | i_DR2);
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    ex_state_e         state_q, state_d;
    uc_t               uc_lat_q, uc_lat_d;
    logic [ADDR_W-1:0] wa_lat_q, wa_lat_d;
    logic [DATA_W-1:0] dr2_lat_q, dr2_lat_d;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;

    ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (i_DR1),
        .b      (i_DR2),
        .done   (mul_done),
        .result (mul_result)
    );

    assign o_stall = (state_q == ST_BUSY);
`else
    assign o_stall = 1'b0;
`endif

    always_comb begin
        valid_d = 1'b0;
        uc_d    = uc_q;
        wa_d    = wa_q;
        alu_d   = alu_q;
        zero_d  = zero_q;
        dr2_d   = dr2_q;
`ifdef EX_MUL_EN
        state_d     = state_q;
        uc_lat_d    = uc_lat_q;
        wa_lat_d    = wa_lat_q;
        dr2_lat_d   = dr2_lat_q;
        mul_start   = i_valid && (state_q == ST_IDLE) && (i_uc_alu_opcode == OP_MUL);
        take_single = i_valid && (state_q == ST_IDLE) && (i_uc_alu_opcode != OP_MUL);
        if (mul_start) begin
            uc_lat_d  = uc_in;
            wa_lat_d  = i_wA;
            dr2_lat_d = i_DR2;
            state_d   = ST_BUSY;
        end
        if ((state_q == ST_BUSY) && mul_done) begin
            valid_d = 1'b1;
            uc_d    = uc_lat_q;
            wa_d    = wa_lat_q;
            alu_d   = mul_result;
            zero_d  = (mul_result == '0);
            dr2_d   = dr2_lat_q;
            state_d = ST_IDLE;
        end
`else
        take_single = i_valid;
`endif
        if (take_single) begin
            valid_d = 1'b1;
            uc_d    = uc_in;
            wa_d    = i_wA;
            alu_d   = alu_res;
            zero_d  = (alu_res == '0);
            dr2_d   = i_DR2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            uc_q      <= '0;
            wa_q      <= '0;
            alu_q     <= '0;
            zero_q    <= 1'b0;
            dr2_q     <= '0;
`ifdef EX_MUL_EN
            state_q   <= ST_IDLE;
            uc_lat_q  <= '0;
            wa_lat_q  <= '0;
            dr2_lat_q <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            uc_q      <= uc_d;
            wa_q      <= wa_d;
            alu_q     <= alu_d;
            zero_q    <= zero_d;
            dr2_q     <= dr2_d;
`ifdef EX_MUL_EN
            state_q   <= state_d;
            uc_lat_q  <= uc_lat_d;
            wa_lat_q  <= wa_lat_d;
            dr2_lat_q <= dr2_lat_d;
`endif
        end
    end

    assign o_valid          = valid_q;
    assign o_uc_e_read_ram  = uc_q.e_read_ram;
    assign o_uc_e_write_ram = uc_q.e_write_ram;
    assign o_uc_demux       = uc_q.demux;
    assign o_uc_e_write_br  = uc_q.e_write_br;
    assign o_wA             = wa_q;
    assign o_alu_result     = alu_q;
    assign o_zero           = zero_q;
    assign o_DR2            = dr2_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier scenarios are compiled when EX_MUL_EN is defined.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_uc_e_read_ram, i_uc_e_write_ram, i_uc_demux, i_uc_e_write_br;
    logic [3:0]  i_uc_alu_opcode;
    logic [4:0]  i_wA;
    logic [31:0] i_DR1, i_DR2;
    logic        o_stall, o_valid;
    logic        o_uc_e_read_ram, o_uc_e_write_ram, o_uc_demux, o_uc_e_write_br;
    logic [4:0]  o_wA;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic [31:0] o_DR2;
    logic [3:0]  o_ctrl;

    int errors = 0;
    int checks = 0;

    ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_uc_e_read_ram  (i_uc_e_read_ram),
        .i_uc_e_write_ram (i_uc_e_write_ram),
        .i_uc_demux       (i_uc_demux),
        .i_uc_alu_opcode  (i_uc_alu_opcode),
        .i_uc_e_write_br  (i_uc_e_write_br),
        .i_wA             (i_wA),
        .i_DR1            (i_DR1),
        .i_DR2            (i_DR2),
        .o_stall          (o_stall),
        .o_valid          (o_valid),
        .o_uc_e_read_ram  (o_uc_e_read_ram),
        .o_uc_e_write_ram (o_uc_e_write_ram),
        .o_uc_demux       (o_uc_demux),
        .o_uc_e_write_br  (o_uc_e_write_br),
        .o_wA             (o_wA),
        .o_alu_result     (o_alu_result),
        .o_zero           (o_zero),
        .o_DR2            (o_DR2)
    );

    assign o_ctrl = {o_uc_e_read_ram, o_uc_e_write_ram, o_uc_demux, o_uc_e_write_br};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {e_read_ram, e_write_ram, demux, e_write_br}
    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] ctrl,
                         input logic [4:0] wa, input logic [31:0] a, input logic [31:0] b);
        i_valid          = v;
        i_uc_alu_opcode  = op;
        i_uc_e_read_ram  = ctrl[3];
        i_uc_e_write_ram = ctrl[2];
        i_uc_demux       = ctrl[1];
        i_uc_e_write_br  = ctrl[0];
        i_wA             = wa;
        i_DR1            = a;
        i_DR2            = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 5'($urandom_range(31)),
                  $urandom, $urandom);
            step();
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", o_stall); end
        checks++; if (o_alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", o_alu_result); end
        checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %0b exp 0", o_zero); end
        checks++; if (o_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", o_ctrl); end
        checks++; if (o_wA !== 5'd0 || o_DR2 !== 32'h0) begin errors++; $display("FAIL reset_wa_dr2 got %0d/%h exp 0/0", o_wA, o_DR2); end
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_add();
        drive(1'b1, OP_ADD, 4'b0001, 5'd7, 32'hFFFF_FFFF, 32'h0000_0002);
        step();
        checks++; if (o_alu_result !== 32'h1) begin errors++; $display("FAIL add_result got %h exp 00000001", o_alu_result); end
        checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL add_zero got %0b exp 0", o_zero); end
        checks++; if (o_wA !== 5'd7) begin errors++; $display("FAIL add_wa got %0d exp 7", o_wA); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", o_valid); end
        checks++; if (o_ctrl !== 4'b0001 || o_DR2 !== 32'h2) begin errors++; $display("FAIL add_ctrl_dr2 got %b/%h exp 0001/00000002", o_ctrl, o_DR2); end
        drive(1'b0, OP_SUB, 4'b1111, 5'd1, 32'h0, 32'h0);
        step();
        checks++; if (o_valid !== 1'b0 || o_alu_result !== 32'h1 || o_wA !== 5'd7) begin
            errors++; $display("FAIL idle_hold got v=%0b r=%h wa=%0d exp v=0 r=00000001 wa=7", o_valid, o_alu_result, o_wA);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_SUB, 4'b0001, 5'd3, 32'd5, 32'd5);
        step();
        checks++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1 || o_valid !== 1'b1) begin
            errors++; $display("FAIL sub_result got r=%h z=%0b v=%0b exp r=0 z=1 v=1", o_alu_result, o_zero, o_valid);
        end
        drive(1'b1, OP_SLT, 4'b0001, 5'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        checks++; if (o_alu_result !== 32'h1 || o_zero !== 1'b0 || o_valid !== 1'b1 || o_wA !== 5'd4) begin
            errors++; $display("FAIL slt_neg got r=%h z=%0b v=%0b wa=%0d exp r=1 z=0 v=1 wa=4", o_alu_result, o_zero, o_valid, o_wA);
        end
        drive(1'b1, OP_SLT, 4'b0001, 5'd5, 32'h0000_0001, 32'hFFFF_FFFF);
        step();
        checks++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
            errors++; $display("FAIL slt_pos got r=%h z=%0b exp r=0 z=1", o_alu_result, o_zero);
        end
        drive(1'b1, OP_AND, 4'b0000, 5'd6, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        checks++; if (o_alu_result !== 32'h0000_F000) begin errors++; $display("FAIL and_result got %h exp 0000f000", o_alu_result); end
        drive(1'b1, OP_OR, 4'b0000, 5'd6, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        checks++; if (o_alu_result !== 32'h0000_FFF0) begin errors++; $display("FAIL or_result got %h exp 0000fff0", o_alu_result); end
        drive(1'b1, OP_NOR, 4'b0000, 5'd6, 32'h0000_0000, 32'h0000_0000);
        step();
        checks++; if (o_alu_result !== 32'hFFFF_FFFF || o_zero !== 1'b0) begin
            errors++; $display("FAIL nor_result got r=%h z=%0b exp r=ffffffff z=0", o_alu_result, o_zero);
        end
        drive(1'b1, 4'b0011, 4'b1010, 5'd12, 32'h1234_5678, 32'hABCD_EF01);
        step();
        checks++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1 || o_ctrl !== 4'b1010 || o_valid !== 1'b1 || o_DR2 !== 32'hABCD_EF01) begin
            errors++; $display("FAIL undef_op got r=%h z=%0b c=%b v=%0b d=%h exp r=0 z=1 c=1010 v=1 d=abcdef01",
                               o_alu_result, o_zero, o_ctrl, o_valid, o_DR2);
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        step();
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul_stall();
        int stall_cycles = 0;
        int valid_seen = 0;
        drive(1'b1, OP_MUL, 4'b0001, 5'd9, 32'h0001_2345, 32'h0000_0100);
        step();
        drive(1'b1, OP_ADD, 4'b0001, 5'd4, 32'd10, 32'd20);
        for (int k = 0; k < 32; k++) begin
            if (o_stall === 1'b1) stall_cycles++;
            if (o_valid !== 1'b0) valid_seen++;
            step();
        end
        checks++; if (stall_cycles != 32) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 32", stall_cycles); end
        checks++; if (valid_seen != 0) begin errors++; $display("FAIL mul_bubbles got %0d valid cycles exp 0", valid_seen); end
        checks++; if (o_stall !== 1'b0 || o_valid !== 1'b1) begin
            errors++; $display("FAIL mul_done got stall=%0b v=%0b exp stall=0 v=1", o_stall, o_valid);
        end
        checks++; if (o_alu_result !== 32'h0123_4500 || o_zero !== 1'b0) begin
            errors++; $display("FAIL mul_result got r=%h z=%0b exp r=01234500 z=0", o_alu_result, o_zero);
        end
        checks++; if (o_wA !== 5'd9 || o_ctrl !== 4'b0001 || o_DR2 !== 32'h100) begin
            errors++; $display("FAIL mul_latched got wa=%0d c=%b d=%h exp wa=9 c=0001 d=00000100", o_wA, o_ctrl, o_DR2);
        end
        step();
        checks++; if (o_alu_result !== 32'd30 || o_wA !== 5'd4 || o_valid !== 1'b1) begin
            errors++; $display("FAIL held_add got r=%h wa=%0d v=%0b exp r=0000001e wa=4 v=1", o_alu_result, o_wA, o_valid);
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL held_add_once got v=%0b exp 0", o_valid); end
    endtask

    task automatic test_mul_wrap();
        int lat = 0;
        drive(1'b1, OP_MUL, 4'b0001, 5'd8, 32'h8000_0000, 32'h0000_0002);
        step();
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        while (o_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        checks++; if (lat != 32) begin errors++; $display("FAIL mul_wrap_latency got %0d exp 32", lat); end
        checks++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1) begin
            errors++; $display("FAIL mul_wrap got r=%h z=%0b exp r=0 z=1", o_alu_result, o_zero);
        end
        step();
    endtask

    task automatic test_mul_reset();
        int late_valid = 0;
        drive(1'b1, OP_MUL, 4'b0101, 5'd11, 32'd3, 32'd5);
        step();
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 9; k++) step();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL mul_mid_stall got %0b exp 1", o_stall); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (o_stall !== 1'b0 || o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_ctrl !== 4'h0 || o_wA !== 5'd0) begin
            errors++; $display("FAIL mul_reset got stall=%0b v=%0b r=%h c=%b wa=%0d exp all 0", o_stall, o_valid, o_alu_result, o_ctrl, o_wA);
        end
        drive(1'b1, OP_ADD, 4'b0001, 5'd2, 32'd1, 32'd1);
        step();
        checks++; if (o_alu_result !== 32'd2 || o_valid !== 1'b1 || o_stall !== 1'b0 || o_wA !== 5'd2) begin
            errors++; $display("FAIL post_reset_add got r=%h v=%0b stall=%0b wa=%0d exp r=2 v=1 stall=0 wa=2", o_alu_result, o_valid, o_stall, o_wA);
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_valid !== 1'b0 || o_stall !== 1'b0) late_valid++;
        end
        checks++; if (late_valid != 0) begin errors++; $display("FAIL mul_discarded got %0d active cycles exp 0", late_valid); end
    endtask
`else
    task automatic test_mul_disabled();
        drive(1'b1, OP_MUL, 4'b0100, 5'd13, 32'd3, 32'd5);
        step();
        checks++; if (o_alu_result !== 32'h0 || o_zero !== 1'b1 || o_valid !== 1'b1) begin
            errors++; $display("FAIL mul_off_result got r=%h z=%0b v=%0b exp r=0 z=1 v=1", o_alu_result, o_zero, o_valid);
        end
        checks++; if (o_stall !== 1'b0 || o_ctrl !== 4'b0100 || o_wA !== 5'd13) begin
            errors++; $display("FAIL mul_off_ctrl got stall=%0b c=%b wa=%0d exp stall=0 c=0100 wa=13", o_stall, o_ctrl, o_wA);
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        step();
        checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL mul_off_single got v=%0b stall=%0b exp 0/0", o_valid, o_stall);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
        test_reset();
        test_add();
        test_back_to_back();
`ifdef EX_MUL_EN
        test_mul_stall();
        test_mul_wrap();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined datapath, placed directly downstream of the decode/execute pipeline register. It receives that register's control bits, write address and two register-bank read operands. It computes the ALU result and registers everything into the execute/memory boundary for the RAM stage. Single-cycle operations complete in one clock; an optional iterative multiplier stalls the upstream register for 32 cycles.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register-bank write-address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream register holds a real instruction
- i_uc_e_read_ram  in  1  RAM read enable
- i_uc_e_write_ram  in  1  RAM write enable
- i_uc_demux  in  1  write-back source select
- i_uc_alu_opcode  in  4  ALU operation
- i_uc_e_write_br  in  1  register-bank write enable
- i_wA  in  ADDR_W  destination register
- i_DR1  in  DATA_W  operand A
- i_DR2  in  DATA_W  operand B, also the store data
- o_stall  out  1  upstream register must hold its contents
- o_valid  out  1  outputs carry a completed instruction
- o_uc_e_read_ram, o_uc_e_write_ram, o_uc_demux, o_uc_e_write_br  out  1 each  registered control bits
- o_wA  out  ADDR_W  registered destination
- o_alu_result  out  DATA_W  registered ALU result
- o_zero  out  1  registered flag, set when o_alu_result equals 0
- o_DR2  out  DATA_W  registered store data

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR: single-cycle.
  - 1000 MUL: multi-cycle when enabled.
  - Any other opcode: result 0, with control bits passed through unchanged.
- ADD, SUB and MUL wrap modulo 2^DATA_W. MUL returns the low DATA_W bits of the product. No overflow flag.
- States:
  - IDLE, BUSY.
  - IDLE with i_valid=1 and a non-MUL opcode: register all outputs and set o_valid=1; stay in IDLE.
  - IDLE with i_valid=1 and MUL: latch the control bits, wA, DR2 and both operands; clear the counter; set o_valid=0; go to BUSY.
  - IDLE with i_valid=0: o_valid=0 and the other outputs hold their values.
  - BUSY: one shift-add step per clock:
    - if the multiplier LSB is 1, add the multiplicand to the accumulator;
    - shift the multiplicand left by 1 and the multiplier right by 1;
    - increment the counter.
  - BUSY at count 31: perform the final step and write the accumulator result to o_alu_result. Drive the latched control bits, o_valid=1 and o_zero from that result. Go to IDLE.
- In BUSY, all i_* inputs are ignored.
- o_stall = (state == BUSY). It is driven straight from the registered state, with no combinational path from the inputs.
- Reset sets every output to 0, the state to IDLE, the counter to 0 and the accumulator to 0.

## Timing
- Single-cycle op sampled at edge N: outputs valid after edge N, with o_valid high for that cycle. Back-to-back issue is allowed every cycle.
- MUL accepted at edge N:
  - o_stall is high from edge N+1 through edge N+32 (the first cycle BUSY is asserted is between edges N and N+1).
  - The result and o_valid=1 appear after edge N+32, with latency exactly 32 cycles.
  - o_valid is 0 in every BUSY cycle, so bubbles go to the RAM stage.
- The instruction that upstream loaded at edge N is held under o_stall and accepted at edge N+33. No instruction is lost or duplicated.
- Counter wrap 31→0 coincides with the BUSY→IDLE transition.
- rst=1 in any cycle, including mid-MUL: after that edge, state is IDLE and all outputs are 0 (o_stall=0, o_valid=0); the partial product is discarded.
- rst takes priority over i_valid in the same cycle.

## Configuration
- EX_MUL_EN defined:
  - the MUL opcode, the BUSY state, the multiplier datapath and the stall behaviour are present.
- EX_MUL_EN undefined:
  - opcode 1000 behaves like any other undefined opcode: result 0, single cycle;
  - o_stall is tied to 0;
  - the FSM reduces to IDLE only.

## Structure
- Shared package ex_pkg holds:
  - the opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL);
  - the state encoding (ST_IDLE, ST_BUSY);
  - MUL_CYCLES = 32.
- One sub-module, ex_mul_iter: the shift-add datapath plus counter with start/done pins, instantiated only under EX_MUL_EN.
- The ALU decode and the output registers stay in ex_stage.

## Test plan
- rst held 2 cycles with random inputs -> all outputs 0, o_stall=0.
- ADD 0xFFFFFFFF + 0x00000002, wA=7, e_write_br=1 -> next cycle o_alu_result=0x00000001, o_zero=0, o_wA=7, o_valid=1.
- SUB 5-5 then SLT 0xFFFFFFFF vs 0x00000001 on back-to-back cycles -> results 0 with o_zero=1, then 1; o_valid=1 on both cycles.
- MUL 0x00012345 × 0x00000100 followed by an ADD held upstream -> o_stall high for 32 cycles, o_valid low throughout, then o_alu_result=0x01234500 with o_valid=1. The held ADD completes exactly once, on the next cycle.
- MUL 0x80000000 × 2 -> o_alu_result=0, o_zero=1, wrap verified.
- rst asserted on BUSY cycle 10 -> outputs 0 and o_stall=0 the next cycle. A new ADD issued afterwards completes normally.
